// File: rtl/pdm_mic_tx.sv
// rtl/pdm_mic_tx.sv - PCM-to-PDM transmitter emulating a digital MEMS microphone
//
// Takes signed PCM samples on a valid/ready stream and buffers them in a
// small FIFO. A first-order sigma-delta modulator turns the current sample
// into a 1-bit stream. The stream is launched in the slot picked by channel,
// relative to an externally supplied PDM bit clock.
//
// Optional feature: define PDM_TX_DITHER_EN to add a 1-LSB LFSR dither to the
// modulator input (breaks idle tones). Left undefined, the output is fully
// deterministic.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            modulator enable (outputs forced low when 0)
//   pdm_clk       PDM bit clock from the receiver, sampled (never a clock)
//   channel       1 = launch on pdm_clk rise (right), 0 = on fall (left)
//   hold_num      each sample is used for hold_num+1 active edges
//   s_data/s_valid/s_ready  PCM sample stream in
//   pdm_data      PDM bit out
//   pdm_oe        high during our slot, emulating the mic tri-state
//   fifo_level    current FIFO occupancy
//   underrun      sticky: a reload found the FIFO empty
//   underrun_clr  clears underrun (a simultaneous set wins)
module pdm_mic_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          pdm_clk,
  input  logic                          channel,
  input  logic [7:0]                    hold_num,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          pdm_data,
  output logic                          pdm_oe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              in_reset;   // keeps s_ready low through reset

  logic              sync1;
  logic              sync2;
  logic              prev;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] cur;
  logic [7:0]        hold_cnt;

  logic              rise;
  logic              fall;
  logic              act_edge;
  logic              inact_edge;
  logic              full;
  logic              empty;
  logic              push;
  logic              reload;
  logic              pop;
  logic [DATA_W-1:0] u;
  logic [DATA_W-1:0] u_mod;
  logic [DATA_W:0]   acc_next;

  assign rise       = sync2 & ~prev;
  assign fall       = ~sync2 & prev;
  assign act_edge   = channel ? rise : fall;
  assign inact_edge = channel ? fall : rise;

  assign full    = (fifo_level == FULL_LVL);
  assign empty   = (fifo_level == '0);
  assign s_ready = ~in_reset & ~full;
  assign push    = s_valid & s_ready;
  assign reload  = en & act_edge & (hold_cnt == hold_num);
  assign pop     = reload & ~empty;

  // Signed sample to offset binary: midscale (0) maps to 2^(DATA_W-1).
  assign u = {~cur[DATA_W-1], cur[DATA_W-2:0]};

`ifdef PDM_TX_DITHER_EN
  logic [15:0] lfsr;

  // Saturate so full-scale positive input never wraps to zero density.
  assign u_mod = (&u) ? u : u + DATA_W'(lfsr[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (en && act_edge) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`else
  assign u_mod = u;
`endif

  // The carry out of the accumulator is the PDM bit.
  assign acc_next = {1'b0, acc} + {1'b0, u_mod};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reset   <= 1'b1;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      acc        <= '0;
      cur        <= '0;
      hold_cnt   <= 8'd0;
      pdm_data   <= 1'b0;
      pdm_oe     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      in_reset <= 1'b0;
      sync1    <= pdm_clk;
      sync2    <= sync1;
      prev     <= sync2;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level <= fifo_level + LW'(push) - LW'(pop);

      if (underrun_clr) begin
        underrun <= 1'b0;
      end

      if (!en) begin
        pdm_data <= 1'b0;
        pdm_oe   <= 1'b0;
      end else if (act_edge) begin
        pdm_data <= acc_next[DATA_W];
        acc      <= acc_next[DATA_W-1:0];
        pdm_oe   <= 1'b1;
        if (reload) begin
          hold_cnt <= 8'd0;
          if (!empty) begin
            cur <= mem[rd_ptr];
          end else begin
            cur      <= '0;
            underrun <= 1'b1;
          end
        end else begin
          // 8-bit wrap: a counter already past hold_num runs through 255.
          hold_cnt <= hold_cnt + 8'd1;
        end
      end else if (inact_edge) begin
        pdm_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_tx.sv
// tb/tb_pdm_mic_tx.sv - self-checking bench for pdm_mic_tx
module tb_pdm_mic_tx;

  localparam int DW = 16;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pdm_clk = 1'b0;
  logic        channel = 1'b1;
  logic [7:0]  hold_num = 8'd0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        s_ready;
  logic        pdm_data;
  logic        pdm_oe;
  logic [2:0]  fifo_level;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  pdm_mic_tx #(.DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .pdm_clk(pdm_clk), .channel(channel),
    .hold_num(hold_num), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pdm_data(pdm_data), .pdm_oe(pdm_oe), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue for the FIFO, integers for the sample,
  // the accumulator sum and the hold count.
  int q[$];
  int m_cur;
  int m_acc;
  int m_cnt;
  bit m_data, m_oe, m_und, m_inrst, started;
  bit h0, h1, h2;   // pdm_clk as sampled 1, 2 and 3 clocks ago

  always @(posedge clk) begin
    bit ready, now_v, old_v, rise, fall, act, inact;
    int total;
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_cur = 0; m_acc = 0; m_cnt = 0;
      m_data = 0; m_oe = 0; m_und = 0; m_inrst = 1;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      ready = !m_inrst && q.size() < D;
      // An edge reaches the outputs on the 3rd clock after the transition.
      now_v = h1;
      old_v = h2;
      h2 = h1; h1 = h0; h0 = pdm_clk;
      rise  = now_v && !old_v;
      fall  = !now_v && old_v;
      act   = channel ? rise : fall;
      inact = channel ? fall : rise;
      if (underrun_clr) m_und = 0;
      if (!en) begin
        m_data = 0;
        m_oe = 0;
      end else if (act) begin
        total  = m_acc + m_cur + 32768;
        m_data = (total >= 65536);
        m_acc  = total % 65536;
        m_oe   = 1;
        if (m_cnt == int'(hold_num)) begin
          m_cnt = 0;
          if (q.size() > 0) m_cur = q.pop_front();
          else begin
            m_cur = 0;
            m_und = 1;
          end
        end else begin
          m_cnt = (m_cnt + 1) % 256;
        end
      end else if (inact) begin
        m_oe = 0;
      end
      if (s_valid && ready) q.push_back(int'($signed(s_data)));
      m_inrst = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_pdm_data", pdm_data, m_data);
      chk("model_pdm_oe", pdm_oe, m_oe);
      chk("model_underrun", underrun, m_und);
      chk("model_fifo_level", fifo_level, q.size());
      chk("model_s_ready", s_ready, (!m_inrst && q.size() < D));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    chk("rst_pdm_data", pdm_data, 0);
    chk("rst_pdm_oe", pdm_oe, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_s_ready", s_ready, 1);
  endtask

  task automatic push(input logic [15:0] d);
    int n;
    s_data = d;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 500) begin
      tick(1);
      n++;
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: s_ready stayed 0, required 1");
    end
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic half(input logic v);
    pdm_clk = v;
    tick(6);
  endtask

  // One full pdm_clk period; b is the bit launched in our slot.
  task automatic pcyc(output logic b);
    half(1'b1);
    if (en) chk("oe_after_rise", pdm_oe, channel);
    if (channel) b = pdm_data;
    half(1'b0);
    if (en) chk("oe_after_fall", pdm_oe, !channel);
    if (!channel) b = pdm_data;
  endtask

  logic b;
  logic [3:0] pat;

  initial begin
    // 1: midscale from reset gives alternating bits starting with 0
    do_reset();
    channel = 1'b1; hold_num = 8'd255; en = 1'b1;
    push(16'h0000);
    pat = 4'b1010;   // bit i of pattern = expected bit on edge i
    for (int i = 0; i < 4; i++) begin
      pcyc(b);
      chk("midscale_bit", b, pat[i]);
    end

    // 2: 0x8000 gives all zeros, 0x7FFF all ones after the midscale edge
    do_reset();
    hold_num = 8'd0; en = 1'b1;
    push(16'h8000);
    pcyc(b);
    hold_num = 8'd255;
    for (int i = 0; i < 4; i++) begin
      pcyc(b);
      chk("neg_full_bit", b, 0);
    end
    do_reset();
    hold_num = 8'd0; en = 1'b1;
    push(16'h7FFF);
    pcyc(b);
    hold_num = 8'd255;
    for (int i = 0; i < 4; i++) begin
      pcyc(b);
      chk("pos_full_bit", b, 1);
    end

    // 3: hold/reload and underrun
    do_reset();
    hold_num = 8'd0; en = 1'b1;
    push(16'h4000);
    pcyc(b);
    chk("reload_a_level", fifo_level, 0);
    hold_num = 8'd3;
    push(16'hC000);
    chk("b_queued_level", fifo_level, 1);
    for (int i = 0; i < 3; i++) pcyc(b);
    chk("b_still_queued", fifo_level, 1);
    pcyc(b);
    chk("b_loaded_level", fifo_level, 0);
    chk("no_underrun_yet", underrun, 0);
    for (int i = 0; i < 3; i++) pcyc(b);
    chk("underrun_before_reload", underrun, 0);
    pcyc(b);
    chk("underrun_set", underrun, 1);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // 4: backpressure with no active edges
    do_reset();
    en = 1'b0;
    push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
    chk("full_level", fifo_level, 4);
    chk("full_s_ready", s_ready, 0);
    s_data = 16'h0005;
    s_valid = 1'b1;
    tick(10);
    chk("held_level", fifo_level, 4);
    hold_num = 8'd0; en = 1'b1; channel = 1'b1;
    pcyc(b);
    chk("refill_level", fifo_level, 4);
    s_valid = 1'b0;
    tick(2);

    // 5: left slot, 3-clock latency from pdm_clk fall
    do_reset();
    channel = 1'b0; en = 1'b1; hold_num = 8'd255;
    push(16'h0000);
    half(1'b1);
    pdm_clk = 1'b0;
    tick(2);
    chk("lat_oe_2clk", pdm_oe, 0);
    tick(1);
    chk("lat_oe_3clk", pdm_oe, 1);
    tick(3);
    half(1'b1);
    pdm_clk = 1'b0;
    tick(2);
    chk("lat_data_2clk", pdm_data, 0);
    tick(1);
    chk("lat_data_3clk", pdm_data, 1);
    tick(3);

    // 6: en low for 10 edges, then reset mid-stream
    en = 1'b0;
    for (int i = 0; i < 10; i++) pcyc(b);
    chk("dis_pdm_data", pdm_data, 0);
    chk("dis_pdm_oe", pdm_oe, 0);
    en = 1'b1;
    push(16'h1234);
    push(16'h5678);
    pcyc(b);
    half(1'b1);
    rst = 1'b1;
    tick(1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_data", pdm_data, 0);
    chk("midrst_oe", pdm_oe, 0);
    rst = 1'b0;
    half(1'b0);
    channel = 1'b1; hold_num = 8'd255;
    push(16'h0000);
    pcyc(b);
    chk("after_rst_bit0", b, 0);
    pcyc(b);
    chk("after_rst_bit1", b, 1);

    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
